alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Multi-cycle ALU feeding the per-core accumulator register (AC). Takes A (current AC value) and
//  B (operand register/bus), runs one op per start, and returns the result with a one-cycle
//  alu_to_ac strobe that the AC uses to load datain_alu. MUL is iterative shift-add, used for the
//  multiply-accumulate steps of matrix multiplication. All other ops complete in one cycle.
// PARAMETERS
//  WIDTH    16  data width; must match the AC width.
//  CNT_W    5   multiply step counter width; needs 2**CNT_W > WIDTH-1.
// PORTS
//  clock      in   1      single clock, all state updates on posedge.
//  reset      in   1      asynchronous, active-high; clears all state.
//  start      in   1      begin an operation; sampled only when accepting (see below).
//  op         in   3      operation code, sampled with start.
//  wb         in   1      1 = write the result back to AC, 0 = flags only; sampled with start.
//  a_in       in   WIDTH  operand A (AC output), sampled with start.
//  b_in       in   WIDTH  operand B, sampled with start.
//  busy       out  1      high while a MUL is in progress.
//  done       out  1      one-cycle pulse: result/flags valid.
//  alu_to_ac  out  1      done & wb_q; drives the AC's alu_to_ac.
//  alu_out    out  WIDTH  result; holds its value until the next completion.
//  zero       out  1      alu_out == 0; updates with alu_out.
//  ovf        out  1      ADD carry-out, SUB borrow, MUL high half nonzero, INC/DEC wrap; else 0.
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, alu_to_ac, alu_out, zero, ovf, and internal registers = 0.
//  Reset mid-MUL aborts the operation. No done is produced for the aborted op.
//  Opcodes: 0 PASSB (B); 1 ADD (A+B); 2 SUB (A-B); 3 MUL (A*B, low WIDTH bits);
//   4 INC (A+1); 5 DEC (A-1); 6 AND (A&B); 7 reserved (result 0, ovf 0, done still pulses).
//  Arithmetic is unsigned and modulo 2**WIDTH. Results are truncated to WIDTH bits.
//  States: IDLE, MUL, DONE.
//  - Accepting = state IDLE or DONE. busy = (state==MUL). start while busy is ignored.
//  - Single-cycle op: start at edge E0 registers alu_out/zero/ovf and sets state=DONE.
//    done=1 for the cycle after E0 (latency 1).
//  - MUL: at E0, latch mcand={WIDTH'0,A}, mplier=B, acc=0, cnt=0, state=MUL.
//    Each later edge: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++.
//    The edge with cnt==WIDTH-1 performs the final step, writes alu_out=acc_next[WIDTH-1:0]
//    and ovf=|acc_next[2W-1:W], and sets state=DONE.
//    done is high WIDTH+1 cycles after start (17 for WIDTH=16). busy is high for WIDTH cycles.
//  - DONE lasts one cycle: done=1, alu_to_ac=wb_q.
//    Next state is IDLE, or a new op if start=1 in that cycle (back-to-back, one op per 2 cycles).
//  - alu_out, zero, ovf change only at completion and remain stable between done pulses.
//  - In the done cycle the AC may also see write_en. Arbitration is the AC's responsibility (alu_to_ac wins).
// STRUCTURE
//  Shared package alu_pkg holds:
//   - op encodings (OP_PASSB..OP_AND) as localparams/typedef,
//   - the state typedef {IDLE, MUL, DONE},
//   - WIDTH default.
//  One natural sub-module: shift_add_mul holds mcand/mplier/acc/cnt.
//   - Ports: clock, reset, load, a, b, step_en, last, product[2W-1:0].
//  The FSM, single-cycle datapath and output registers stay in alu_seq.
// TESTING
//  1 Reset: assert reset mid-sim, including during MUL cycle 5 -> all outputs 0, state IDLE,
//    no done pulse afterwards.
//  2 ADD: A=16'hFFFF, B=2, wb=1 -> one cycle later done=1, alu_to_ac=1, alu_out=1, ovf=1, zero=0.
//  3 MUL: A=300, B=250 -> busy for 16 cycles, done at cycle 17, alu_out=16'h24F8 (75000 mod 65536),
//    ovf=1. A=12, B=11 -> 132, ovf=0.
//  4 Busy rule: start with op=ADD pulsed during MUL -> ignored; only the MUL done occurs.
//  5 Back-to-back: start held high with SUB A=5,B=5 then INC A=0 -> done pulses on alternate cycles.
//    alu_out=0 with zero=1, then alu_out=1 with zero=0.
//  6 wb=0 with DEC A=0 -> done=1, alu_to_ac=0, alu_out=16'hFFFF, ovf=1.
//    AC connected downstream keeps its old value.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: default width, opcodes and FSM states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    localparam logic [2:0] OP_PASSB = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_INC   = 3'd4;
    localparam logic [2:0] OP_DEC   = 3'd5;
    localparam logic [2:0] OP_AND   = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, one partial product per step.
// Ports: clock, reset (async, active-high), load (latch a/b and clear),
//        step_en (perform one step), last (current step is the final one),
//        product (accumulator value after the current step, combinational).
module shift_add_mul #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 step_en,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    // Accumulator value after this step; the parent samples it on the last step.
    always_comb begin
        product = acc_q;
        if (mplier_q[0]) begin
            product = acc_q + mcand_q;
        end
    end

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // Multiplier state: load clears, each step consumes one multiplier bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_en) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU feeding the accumulator. Single-cycle ops finish one edge after
// start; MUL runs WIDTH shift-add steps. done pulses for one cycle per completed op.
// Ports: clock, reset (async, active-high), start/op/wb/a_in/b_in (request),
//        busy (MUL in progress), done (result valid), alu_to_ac (done & write-back),
//        alu_out/zero/ovf (result and flags, held between completions).
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             wb,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             alu_to_ac,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf
);

    alu_state_e state_q, state_d;

    logic             pend_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             wb_q;

    logic             mul_load_c, step_c, fin_c, fin_mul_c, latch_c, use_pend_c, wb_fin_c;
    logic             last_c;
    logic [2*WIDTH-1:0] product_c;

    logic [2:0]       op_sel_c;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;
    logic [WIDTH:0]   ext_c;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    shift_add_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load_c),
        .a       (a_in),
        .b       (b_in),
        .step_en (step_c),
        .last    (last_c),
        .product (product_c)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control. A single-cycle op accepted in DONE is parked and
    // executed from IDLE on the following edge, so back-to-back ops complete every
    // other cycle and each completion gets its own done pulse.
    always_comb begin
        state_d    = state_q;
        mul_load_c = 1'b0;
        step_c     = 1'b0;
        fin_c      = 1'b0;
        fin_mul_c  = 1'b0;
        latch_c    = 1'b0;
        use_pend_c = 1'b0;
        wb_fin_c   = wb;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    use_pend_c = 1'b1;
                    fin_c      = 1'b1;
                    wb_fin_c   = wb_q;
                    state_d    = DONE;
                end else if (start) begin
                    if (op == OP_MUL) begin
                        mul_load_c = 1'b1;
                        state_d    = MUL;
                    end else begin
                        fin_c   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                step_c = 1'b1;
                if (last_c) begin
                    fin_c     = 1'b1;
                    fin_mul_c = 1'b1;
                    wb_fin_c  = wb_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load_c = 1'b1;
                        state_d    = MUL;
                    end else begin
                        latch_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and flag selection: multiplier product or single-cycle datapath.
    always_comb begin
        op_sel_c = use_pend_c ? op_q : op;
        a_sel_c  = use_pend_c ? a_q  : a_in;
        b_sel_c  = use_pend_c ? b_q  : b_in;
        ext_c    = '0;
        res_c    = '0;
        ovf_c    = 1'b0;
        if (fin_mul_c) begin
            res_c = product_c[WIDTH-1:0];
            ovf_c = |product_c[2*WIDTH-1:WIDTH];
        end else begin
            case (op_sel_c)
                OP_PASSB: res_c = b_sel_c;
                OP_ADD:   ext_c = {1'b0, a_sel_c} + {1'b0, b_sel_c};
                OP_SUB:   ext_c = {1'b0, a_sel_c} - {1'b0, b_sel_c};
                OP_INC:   ext_c = {1'b0, a_sel_c} + (WIDTH+1)'(1);
                OP_DEC:   ext_c = {1'b0, a_sel_c} - (WIDTH+1)'(1);
                OP_AND:   res_c = a_sel_c & b_sel_c;
                default:  res_c = '0;
            endcase
            // Carry/borrow lands in the extension bit for all four arithmetic ops.
            if (op_sel_c == OP_ADD || op_sel_c == OP_SUB ||
                op_sel_c == OP_INC || op_sel_c == OP_DEC) begin
                res_c = ext_c[WIDTH-1:0];
                ovf_c = ext_c[WIDTH];
            end
        end
    end

    // Output registers and parked-request registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_to_ac <= 1'b0;
            alu_out   <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            pend_q    <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wb_q      <= 1'b0;
        end else begin
            busy      <= (state_d == MUL);
            done      <= fin_c;
            alu_to_ac <= fin_c & wb_fin_c;
            pend_q    <= latch_c;
            if (fin_c) begin
                alu_out <= res_c;
                zero    <= (res_c == '0);
                ovf     <= ovf_c;
            end
            if (latch_c) begin
                op_q <= op;
                a_q  <= a_in;
                b_q  <= b_in;
            end
            if (mul_load_c || latch_c) begin
                wb_q <= wb;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes model results, the monitor
// pops and compares on every done pulse and checks outputs hold in between.
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        wb;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic        alu_to_ac;
    logic [15:0] alu_out;
    logic        zero;
    logic        ovf;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        wb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    logic [15:0] hold_res = '0;
    logic        hold_zero = 1'b0;
    logic        hold_ovf = 1'b0;

    alu_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .wb        (wb),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .alu_to_ac (alu_to_ac),
        .alu_out   (alu_out),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain unsigned arithmetic on 16-bit values.
    function automatic exp_t model(input int op_i, input longint unsigned a, input longint unsigned b,
                                   input logic wb_i);
        exp_t e;
        longint unsigned r;
        logic ov;
        ov = 1'b0;
        case (op_i)
            0: r = b;
            1: begin r = a + b;  ov = (r > 65535); end
            2: begin r = (a + 65536 - b) % 65536; ov = (a < b); end
            3: begin r = a * b;  ov = (r > 65535); end
            4: begin r = a + 1;  ov = (r > 65535); end
            5: begin r = (a + 65535) % 65536; ov = (a == 0); end
            6: r = a & b;
            default: r = 0;
        endcase
        e.res = 16'(r % 65536);
        e.ovf = ov;
        e.wb  = wb_i;
        return e;
    endfunction

    // Monitor: compare on done, otherwise outputs must hold their last result.
    always @(negedge clock) begin
        if (reset) begin
            hold_res  = '0;
            hold_zero = 1'b0;
            hold_ovf  = 1'b0;
        end else if (done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("alu_out", 32'(alu_out), 32'(e.res));
                check("zero", 32'(zero), 32'(e.res == 16'h0));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("alu_to_ac", 32'(alu_to_ac), 32'(e.wb));
                hold_res  = e.res;
                hold_zero = (e.res == 16'h0);
                hold_ovf  = e.ovf;
            end
        end else begin
            check("hold_out", 32'({alu_out, zero, ovf, alu_to_ac}),
                  32'({hold_res, hold_zero, hold_ovf, 1'b0}));
        end
    end

    // Issue one op from idle, wait (bounded) for done and check latency/busy time.
    // inject pulses an ADD start three cycles in, which a running MUL must ignore.
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic w, input bit inject);
        int lat;
        int bcnt;
        @(negedge clock);
        op = o; a_in = a; b_in = b; wb = w; start = 1'b1;
        sb.push_back(model(int'(o), longint'(a), longint'(b), w));
        lat = 0;
        bcnt = 0;
        do begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            if (inject && lat == 3) begin
                start = 1'b1; op = 3'd1; a_in = 16'h0001; b_in = 16'h0001;
            end
            if (busy) bcnt++;
        end while (!done && lat < 40);
        start = 1'b0;
        check("latency", 32'(lat), (o == 3'd3) ? 32'd17 : 32'd1);
        if (o == 3'd3) check("busy_cycles", 32'(bcnt), 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; op = '0; wb = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clock);
        check("reset_outs", 32'({busy, done, alu_to_ac, alu_out, zero, ovf}), 32'd0);
        reset = 1'b0;

        issue(3'd1, 16'hFFFF, 16'h0002, 1'b1, 1'b0);   // ADD with carry
        issue(3'd3, 16'd300, 16'd250, 1'b1, 1'b0);     // MUL with high half
        issue(3'd3, 16'd12, 16'd11, 1'b1, 1'b0);       // MUL fits
        issue(3'd3, 16'd7, 16'd9, 1'b0, 1'b1);         // ADD start during MUL ignored
        issue(3'd5, 16'h0000, 16'h1234, 1'b0, 1'b0);   // DEC wrap, flags only
        issue(3'd4, 16'hFFFF, 16'h0000, 1'b1, 1'b0);   // INC wrap
        issue(3'd7, 16'h1234, 16'h5678, 1'b1, 1'b0);   // reserved
        repeat (3) @(negedge clock);

        // Back-to-back: start stays high across the done cycle.
        op = 3'd2; a_in = 16'd5; b_in = 16'd5; wb = 1'b1; start = 1'b1;
        sb.push_back(model(2, 5, 5, 1'b1));
        @(negedge clock);
        check("b2b_done0", 32'(done), 32'd1);
        op = 3'd4; a_in = 16'd0; b_in = 16'd0;
        sb.push_back(model(4, 0, 0, 1'b1));
        @(negedge clock);
        check("b2b_gap", 32'(done), 32'd0);
        start = 1'b0;
        @(negedge clock);
        check("b2b_done1", 32'(done), 32'd1);
        repeat (2) @(negedge clock);

        // Reset during MUL step 5 aborts with no done afterwards.
        op = 3'd3; a_in = 16'd300; b_in = 16'd250; wb = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_mul_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_mul_reset_outs", 32'({busy, done, alu_to_ac, alu_out, zero, ovf}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        d0 = done_count;
        repeat (25) @(negedge clock);
        check("no_done_after_abort", 32'(done_count), 32'(d0));

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (3) @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
